rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Owns the single RegisterFile write port (W_result / MW_insn_dst / write-enable) and shares it between two result sources: the fixed-latency ALU path and the handshaked load/store (LSU) path.
- Keeps a per-register busy scoreboard so decode stalls while any source or destination register has a result outstanding.
- Sits between execute/LSU and the RegisterFile; the stall output goes to the FD stage.

Parameters:
- DATA_W, 8, register data width (matches REG_RANGE width)
- PTR_W, 4, register pointer width (matches REG_PTR_RANGE width)
- REG_COUNT, 16, number of registers, 2**PTR_W
- LSU_FIFO_DEPTH, 2, LSU result buffer entries, power of two, >=2

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- alu_wb_valid  in  1  ALU result present this cycle; cannot be back-pressured
- alu_wb_dst  in  PTR_W  ALU destination register
- alu_wb_data  in  DATA_W  ALU result
- lsu_wb_valid  in  1  LSU result offered
- lsu_wb_ready  out  1  LSU result accepted when valid & ready
- lsu_wb_dst  in  PTR_W  LSU destination register
- lsu_wb_data  in  DATA_W  LSU result
- iss_valid  in  1  decode wants to issue
- iss_has_dst  in  1  issuing instruction writes a register
- iss_dst  in  PTR_W  destination of issuing instruction
- iss_src_0 / iss_src_1 / iss_src_2  in  PTR_W each  sources of issuing instruction
- iss_stall  out  1  issue blocked this cycle (combinational)
- rf_we  out  1  RegisterFile write enable (registered)
- rf_dst  out  PTR_W  RegisterFile write pointer (registered)
- rf_data  out  DATA_W  RegisterFile write data (registered)
- busy  out  REG_COUNT  scoreboard vector (registered)

Behaviour:
- Reset (sync, active-high): rf_we=0, rf_dst=0, rf_data=0, busy=0, FIFO emptied (lsu_wb_ready=1 in the next cycle). A reset asserted mid-operation discards FIFO contents and pending busy bits; no write is issued in the cycle after reset.
- lsu_wb_ready = !fifo_full. This is registered state only and has no combinational path from lsu_wb_valid.
- Write-port arbitration, evaluated in cycle N:
  - ALU has strict priority: if alu_wb_valid, the cycle-N+1 outputs are rf_we=1 with alu dst/data.
  - Otherwise, if the FIFO is non-empty, the head entry is popped and written in N+1.
  - Otherwise rf_we=0 in N+1; rf_dst and rf_data hold their previous values.
- Latency: ALU input to rf_we is 1 cycle. LSU handshake to rf_we is at least 2 cycles (push, then pop).
- FIFO: push and pop may occur in the same cycle when full. A pop frees the slot at the same edge, but ready is still computed from the pre-edge count. Pointers wrap modulo LSU_FIFO_DEPTH. Order is strictly FIFO.
- LSU starvation is permitted while ALU results keep arriving back to back; no fairness is provided.
- Scoreboard:
  - busy[k] is set at the edge where (iss_valid & !iss_stall & iss_has_dst & iss_dst==k).
  - busy[k] is cleared at the edge ending a cycle where rf_we & rf_dst==k. The RegisterFile commits at that same edge, so a reader issued in the following cycle sees the new value.
  - If a set and a clear hit the same k in one cycle, the set wins.
- iss_stall = iss_valid & (busy[src_0] | busy[src_1] | busy[src_2] | (iss_has_dst & busy[iss_dst])). There is no bypass of an in-flight commit.
- Writes to register 0 are scheduled like any other register; R0 initialisation is handled outside this block.

Optional Feature:
- RF_WB_CHECK_EN defined:
  - Adds output wb_err (1 bit, sticky until reset, reset value 0).
  - wb_err sets when a write is selected for a register whose busy bit is 0.
  - wb_err also sets when lsu_wb_valid & !lsu_wb_ready persists while alu_wb_valid has been high for 2**PTR_W consecutive cycles (starvation watchdog).
- RF_WB_CHECK_EN undefined: no wb_err port, no checker logic.

Decomposition:
- Shared package/def file: DATA_W, PTR_W and REG_COUNT constants, and the wb-source select encoding (SRC_NONE, SRC_ALU, SRC_LSU).
- One sub-module, rf_wb_fifo:
  - parameterised DATA_W+PTR_W wide, LSU_FIFO_DEPTH deep
  - ports: push, pop, full, empty, head
- Arbitration and scoreboard stay in the top module.

Test Plan:
- ALU only: alu_wb_valid=1, dst=3, data=0x5A at cycle 0 -> rf_we=1, rf_dst=3, rf_data=0x5A at cycle 1; rf_we=0 at cycle 2.
- Collision: ALU (dst 2, 0x11) and LSU (dst 5, 0x22) both valid at cycle 0 -> cycle 1 writes reg 2; cycle 2 writes reg 5 with 0x22.
- FIFO full: ALU valid every cycle and LSU offering 3 results -> lsu_wb_ready=0 after 2 accepts. Drop ALU -> results drained in order with no loss, then ready=1 again.
- Hazard: issue with dst=7 (has_dst=1), then iss_src_1=7 -> iss_stall=1 until the cycle after rf_we with rf_dst=7; then stall=0 and busy[7]=0.
- Same-cycle set/clear: commit reg 4 while issuing a new writer to reg 4 -> busy[4] remains 1.
- Reset mid-operation: FIFO holding 2 entries and busy=0x00F0, assert reset -> next cycle busy=0, rf_we=0, lsu_wb_ready=1, and the 2 entries are never written.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared constants and write-back source encoding for the RegisterFile write-port scheduler.
package rf_wb_pkg;

    localparam int DATA_W    = 8;
    localparam int PTR_W     = 4;
    localparam int REG_COUNT = 2 ** PTR_W;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small power-of-two FIFO buffering LSU results until the shared write port is free.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int WIDTH = DATA_W + PTR_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A pop frees its slot at the same edge, so a push into a full FIFO is legal alongside it.
    assign do_push = push & (!full | pop);
    assign do_pop  = pop & !empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
        if (do_pop)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the RegisterFile write port between ALU and LSU and keeps the busy scoreboard.
// Optional checker (wb_err) is built when RF_WB_CHECK_EN is defined.
module rf_wb_scheduler
    import rf_wb_pkg::*;
#(
    parameter int DATA_W         = rf_wb_pkg::DATA_W,
    parameter int PTR_W          = rf_wb_pkg::PTR_W,
    parameter int REG_COUNT      = 2 ** PTR_W,
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_wb_valid,
    input  logic [PTR_W-1:0]     alu_wb_dst,
    input  logic [DATA_W-1:0]    alu_wb_data,
    input  logic                 lsu_wb_valid,
    output logic                 lsu_wb_ready,
    input  logic [PTR_W-1:0]     lsu_wb_dst,
    input  logic [DATA_W-1:0]    lsu_wb_data,
    input  logic                 iss_valid,
    input  logic                 iss_has_dst,
    input  logic [PTR_W-1:0]     iss_dst,
    input  logic [PTR_W-1:0]     iss_src_0,
    input  logic [PTR_W-1:0]     iss_src_1,
    input  logic [PTR_W-1:0]     iss_src_2,
    output logic                 iss_stall,
`ifdef RF_WB_CHECK_EN
    output logic                 wb_err,
`endif
    output logic                 rf_we,
    output logic [PTR_W-1:0]     rf_dst,
    output logic [DATA_W-1:0]    rf_data,
    output logic [REG_COUNT-1:0] busy
);

    localparam int EW = DATA_W + PTR_W;

    wb_src_e              src_sel;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [EW-1:0]        fifo_head;
    logic [PTR_W-1:0]     head_dst;
    logic [DATA_W-1:0]    head_data;
    logic                 issue_fire;

    logic                 rf_we_q, rf_we_d;
    logic [PTR_W-1:0]     rf_dst_q, rf_dst_d;
    logic [DATA_W-1:0]    rf_data_q, rf_data_d;
    logic [REG_COUNT-1:0] busy_q, busy_d;

    assign lsu_wb_ready = !fifo_full;
    assign fifo_push    = lsu_wb_valid & lsu_wb_ready;
    assign fifo_pop     = (src_sel == SRC_LSU);
    assign head_dst     = fifo_head[EW-1:DATA_W];
    assign head_data    = fifo_head[DATA_W-1:0];

    rf_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data ({lsu_wb_dst, lsu_wb_data}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // No bypass: a register stays busy until the edge that commits it.
    assign iss_stall  = iss_valid & (busy_q[iss_src_0] | busy_q[iss_src_1] | busy_q[iss_src_2]
                                     | (iss_has_dst & busy_q[iss_dst]));
    assign issue_fire = iss_valid & !iss_stall & iss_has_dst;

    always_comb begin
        src_sel   = SRC_NONE;
        rf_dst_d  = rf_dst_q;
        rf_data_d = rf_data_q;
        if (alu_wb_valid)     src_sel = SRC_ALU;
        else if (!fifo_empty) src_sel = SRC_LSU;
        case (src_sel)
            SRC_ALU: begin
                rf_dst_d  = alu_wb_dst;
                rf_data_d = alu_wb_data;
            end
            SRC_LSU: begin
                rf_dst_d  = head_dst;
                rf_data_d = head_data;
            end
            default: ;
        endcase
        rf_we_d = (src_sel != SRC_NONE);

        // Clear first so a same-cycle set on the same register wins.
        busy_d = busy_q;
        if (rf_we_q)    busy_d[rf_dst_q] = 1'b0;
        if (issue_fire) busy_d[iss_dst]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_dst_q  <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_dst_q  <= rf_dst_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_dst  = rf_dst_q;
    assign rf_data = rf_data_q;
    assign busy    = busy_q;

`ifdef RF_WB_CHECK_EN
    logic             wb_err_q, wb_err_d;
    logic [PTR_W:0]   starve_cnt_q, starve_cnt_d;

    always_comb begin
        wb_err_d     = wb_err_q;
        starve_cnt_d = '0;
        if (src_sel != SRC_NONE && !busy_q[rf_dst_d]) wb_err_d = 1'b1;
        if (alu_wb_valid & lsu_wb_valid & !lsu_wb_ready) begin
            starve_cnt_d = (starve_cnt_q == (PTR_W+1)'(REG_COUNT)) ? starve_cnt_q
                                                                   : starve_cnt_q + 1'b1;
        end
        if (starve_cnt_d == (PTR_W+1)'(REG_COUNT)) wb_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_err_q     <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            wb_err_q     <= wb_err_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign wb_err = wb_err_q;
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler (default build, checker disabled).
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_wb_valid, lsu_wb_valid, lsu_wb_ready;
    logic [3:0]  alu_wb_dst, lsu_wb_dst;
    logic [7:0]  alu_wb_data, lsu_wb_data;
    logic        iss_valid, iss_has_dst, iss_stall;
    logic [3:0]  iss_dst, iss_src_0, iss_src_1, iss_src_2;
    logic        rf_we;
    logic [3:0]  rf_dst;
    logic [7:0]  rf_data;
    logic [15:0] busy;
`ifdef RF_WB_CHECK_EN
    logic        wb_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_dst   (alu_wb_dst),
        .alu_wb_data  (alu_wb_data),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_ready (lsu_wb_ready),
        .lsu_wb_dst   (lsu_wb_dst),
        .lsu_wb_data  (lsu_wb_data),
        .iss_valid    (iss_valid),
        .iss_has_dst  (iss_has_dst),
        .iss_dst      (iss_dst),
        .iss_src_0    (iss_src_0),
        .iss_src_1    (iss_src_1),
        .iss_src_2    (iss_src_2),
        .iss_stall    (iss_stall),
`ifdef RF_WB_CHECK_EN
        .wb_err       (wb_err),
`endif
        .rf_we        (rf_we),
        .rf_dst       (rf_dst),
        .rf_data      (rf_data),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_wb_valid = 0; alu_wb_dst = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_dst = 0; lsu_wb_data = 0;
        iss_valid = 0; iss_has_dst = 0; iss_dst = 0;
        iss_src_0 = 0; iss_src_1 = 0; iss_src_2 = 0;
    endtask

    task automatic alu(input logic [3:0] d, input logic [7:0] v);
        alu_wb_valid = 1; alu_wb_dst = d; alu_wb_data = v;
    endtask

    task automatic lsu(input logic [3:0] d, input logic [7:0] v);
        lsu_wb_valid = 1; lsu_wb_dst = d; lsu_wb_data = v;
    endtask

    task automatic issue(input logic [3:0] d);
        iss_valid = 1; iss_has_dst = 1; iss_dst = d;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;

        // Reset state
        check("rst_we", rf_we, 0);
        check("rst_dst", rf_dst, 0);
        check("rst_data", rf_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", lsu_wb_ready, 1);
        check("rst_stall", iss_stall, 0);

        // ALU only: one-cycle latency, then hold dst/data with we low
        alu(3, 8'h5A);
        tick();
        check("alu_we", rf_we, 1);
        check("alu_dst", rf_dst, 3);
        check("alu_data", rf_data, 8'h5A);
        idle();
        tick();
        check("alu_we_off", rf_we, 0);
        check("alu_dst_hold", rf_dst, 3);
        check("alu_data_hold", rf_data, 8'h5A);

        // Collision: ALU first, buffered LSU result next cycle
        alu(2, 8'h11);
        lsu(5, 8'h22);
        check("col_ready", lsu_wb_ready, 1);
        tick();
        check("col_c1_dst", rf_dst, 2);
        check("col_c1_data", rf_data, 8'h11);
        idle();
        tick();
        check("col_c2_we", rf_we, 1);
        check("col_c2_dst", rf_dst, 5);
        check("col_c2_data", rf_data, 8'h22);
        tick();
        check("col_c3_we", rf_we, 0);

        // FIFO full: ALU hogs the port while LSU offers three results
        alu(1, 8'h01);
        lsu(8, 8'hA1);
        check("full_rdy0", lsu_wb_ready, 1);
        tick();
        lsu(9, 8'hB2);
        check("full_rdy1", lsu_wb_ready, 1);
        tick();
        lsu(10, 8'hC3);
        check("full_rdy2", lsu_wb_ready, 0);
        tick();
        check("full_rdy3", lsu_wb_ready, 0);
        check("full_alu_dst", rf_dst, 1);
        alu_wb_valid = 0;
        tick();
        check("drain_a_dst", rf_dst, 8);
        check("drain_a_data", rf_data, 8'hA1);
        check("drain_rdy", lsu_wb_ready, 1);
        tick();
        lsu_wb_valid = 0;
        check("drain_b_dst", rf_dst, 9);
        check("drain_b_data", rf_data, 8'hB2);
        tick();
        check("drain_c_we", rf_we, 1);
        check("drain_c_dst", rf_dst, 10);
        check("drain_c_data", rf_data, 8'hC3);
        tick();
        check("drain_end_we", rf_we, 0);
        check("drain_end_rdy", lsu_wb_ready, 1);

        // Hazard on r7
        issue(7);
        check("haz_issue_stall", iss_stall, 0);
        tick();
        check("haz_busy_set", busy, 16'h0080);
        idle();
        iss_valid = 1; iss_src_1 = 7;
        check("haz_stall0", iss_stall, 1);
        tick();
        check("haz_stall1", iss_stall, 1);
        alu(7, 8'h77);
        tick();
        alu_wb_valid = 0;
        check("haz_commit_dst", rf_dst, 7);
        check("haz_stall_commit", iss_stall, 1);
        tick();
        check("haz_stall_clear", iss_stall, 0);
        check("haz_busy_clear", busy, 0);
        idle();

        // Same-cycle set/clear on r4: set wins
        alu(4, 8'h44);
        tick();
        idle();
        check("sc_we", rf_we, 1);
        issue(4);
        check("sc_stall", iss_stall, 0);
        tick();
        idle();
        check("sc_busy", busy, 16'h0010);
        alu(4, 8'h45);
        tick();
        idle();
        tick();
        check("sc_busy_done", busy, 0);

        // Reset mid-operation: two buffered entries and busy=0x00F0 are discarded
        alu(1, 8'h0F);
        lsu(12, 8'hCC);
        issue(4);
        tick();
        lsu(13, 8'hDD);
        issue(5);
        tick();
        lsu_wb_valid = 0;
        issue(6);
        tick();
        issue(7);
        tick();
        iss_valid = 0;
        check("mid_busy", busy, 16'h00F0);
        check("mid_ready", lsu_wb_ready, 0);
        idle();
        reset = 1;
        tick();
        reset = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_ready", lsu_wb_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_write", rf_we, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
